pipe_unpack: RTL

- Ready/valid stream width down-converter. Accepts one wide word per handshake and emits it as a sequence of narrow beats on a ready/valid output.
- Sits after a pipe_reg stage on the host-to-DDR instruction/data path. It splits 256-bit host words into per-lane command or data slices.
- The beat count is per word, so short final words emit no padding beats.

---
 rtl/pipe_unpack.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_unpack.sv
// -----------------------------------------------------------------------------
// pipe_unpack
//
// Ready/valid stream width down-converter. One IN_WIDTH word is accepted per
// upstream handshake and replayed as (len+1) OUT_WIDTH beats on the downstream
// ready/valid interface. Short words end early: no padding beats are emitted.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-low reset
//   valid_in   in   1          upstream word valid
//   data_in    in   IN_WIDTH   upstream word
//   len_in     in   CNT_W      beats minus one for this word (clamped to RATIO-1)
//   ready_out  out  1          upstream ready (combinational, zero-bubble reload)
//   valid_out  out  1          downstream beat valid
//   data_out   out  OUT_WIDTH  current beat
//   last_out   out  1          final beat of the current word
//   ready_in   in   1          downstream ready
//
// Build option
//   PIPE_UNPACK_MSB_FIRST_EN : when defined, beat k carries slice RATIO-1-k
//                              (most-significant slice first). Handshake and
//                              timing are unchanged. Default is LSB slice first.
// -----------------------------------------------------------------------------
module pipe_unpack #(
    parameter  int IN_WIDTH  = 256,
    parameter  int OUT_WIDTH = 64,
    localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
    localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic [CNT_W-1:0]     len_in,
    output logic                 ready_out,
    output logic                 valid_out,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 last_out,
    input  logic                 ready_in
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(RATIO - 1);

    // The state register doubles as the "word held" valid flag.
    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IN_WIDTH-1:0]   r_word;
    logic [CNT_W-1:0]      r_len;
    logic [CNT_W-1:0]      r_idx;

    logic                  w_valid;
    logic                  w_last;
    logic                  w_load;
    logic                  w_adv;
    logic [CNT_W-1:0]      w_len_clamp;
    logic [CNT_W-1:0]      w_sel;
    logic [OUT_WIDTH-1:0]  w_data;

    assign w_valid = (r_state == SEND);
    assign w_last  = w_valid & (r_idx == r_len);

    // Compare one bit wider so the check stays meaningful when RATIO is a
    // power of two (every len_in is then legal and the clamp never fires).
    assign w_len_clamp = ({1'b0, len_in} > {1'b0, MAX_LEN}) ? MAX_LEN : len_in;

    // Next-state / load control
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            EMPTY: begin
                if (valid_in) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (ready_in) begin
                    if (w_last) begin
                        // Last beat leaves this cycle: reload in place if a
                        // new word is waiting, otherwise fall back to EMPTY.
                        if (valid_in) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = EMPTY;
                        end
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // State and word registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_word  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_word <= data_in;
                r_len  <= w_len_clamp;
                r_idx  <= '0;
            end else if (w_adv) begin
                r_idx  <= r_idx + CNT_W'(1);
            end
        end
    end

    // Beat slice selection
`ifdef PIPE_UNPACK_MSB_FIRST_EN
    assign w_sel = MAX_LEN - r_idx;
`else
    assign w_sel = r_idx;
`endif

    always_comb begin
        w_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (w_sel == CNT_W'(k)) begin
                w_data = r_word[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign data_out  = w_data;
    assign valid_out = w_valid;
    assign last_out  = w_last;
    assign ready_out = ~w_valid | (ready_in & w_last);

endmodule
